// File: rtl/mem_bus_arbiter.sv
// N-channel arbiter that serialises client memory requests onto one RAM bus.
// One transaction is outstanding at a time. The FSM walks IDLE -> BUSY -> RESP,
// and a request takes at least 3 cycles.
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   cl_read/cl_write    per-channel request levels
//   cl_address/wdata/ws per-channel request fields, packed by channel index
//   cl_rdata            read data broadcast to all channels, valid with cl_ready
//   cl_ready/cl_done    per-channel one-cycle completion pulses
//   mem_*               RAM-side strobes, latched fields and the granted channel ID
//   mem_rdata/ready/done RAM-side responses
module mem_bus_arbiter #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RR_MODE    = 1,
  parameter int unsigned ID_WIDTH   = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [CHANNELS-1:0]            cl_read,
  input  logic [CHANNELS-1:0]            cl_write,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] cl_address,
  input  logic [CHANNELS*DATA_WIDTH-1:0] cl_wdata,
  input  logic [CHANNELS*2-1:0]          cl_ws,
  output logic [DATA_WIDTH-1:0]          cl_rdata,
  output logic [CHANNELS-1:0]            cl_ready,
  output logic [CHANNELS-1:0]            cl_done,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ID_WIDTH-1:0]            mem_source,
  output logic [1:0]                     mem_ws,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  input  logic                           mem_ready,
  input  logic                           mem_done
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant;
  logic                op_write;

  logic [CHANNELS-1:0] req;
  logic                any_req;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] sel;
  int unsigned         idx;

  assign req        = cl_read | cl_write;
  assign mem_source = grant;

  // Winner scan: starts at rr_ptr in round-robin mode and at 0 in fixed priority.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    sel     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = (RR_MODE != 0) ? (32'(rr_ptr) + i) : i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      sel = ID_WIDTH'(idx);
      if (!any_req && req[sel]) begin
        any_req = 1'b1;
        winner  = sel;
      end
    end
  end

  // Transaction FSM. Client inputs are sampled only in IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      op_write    <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_ws      <= '0;
      cl_rdata    <= '0;
      cl_ready    <= '0;
      cl_done     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            // When a channel requests both operations, the write goes first.
            // The read stays pending.
            grant       <= winner;
            op_write    <= cl_write[winner];
            mem_write   <= cl_write[winner];
            mem_read    <= ~cl_write[winner];
            mem_address <= cl_address[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata   <= cl_wdata[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
            mem_ws      <= cl_ws[32'(winner)*2 +: 2];
            state       <= BUSY;
          end
        end
        BUSY: begin
          // A completion that does not match the latched op is ignored.
          if (!op_write && mem_ready) begin
            cl_rdata        <= mem_rdata;
            cl_ready[grant] <= 1'b1;
            mem_read        <= 1'b0;
            state           <= RESP;
          end else if (op_write && mem_done) begin
            cl_done[grant]  <= 1'b1;
            mem_write       <= 1'b0;
            state           <= RESP;
          end
        end
        RESP: begin
          cl_ready <= '0;
          cl_done  <= '0;
          if (RR_MODE != 0) begin
            rr_ptr <= (32'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
